// File: rtl/stone_paper_scissors_if.sv
// Tiny Tapeout style 8-bit I/O bundle for the
// stone/paper/scissors referee.
interface stone_paper_scissors_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/stone_paper_scissors.sv
// Two-player stone/paper/scissors referee with per-player
// scores and a match winner at WIN_SCORE round wins.
module stone_paper_scissors #(
    parameter int WIN_SCORE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    stone_paper_scissors_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, COLLECT, JUDGE, RESULT, OVER
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [3:0] hist_q;
    logic [1:0] p1_mv_q, p1_mv_d;
    logic [1:0] p2_mv_q, p2_mv_d;
    logic       p1_lk_q, p1_lk_d;
    logic       p2_lk_q, p2_lk_d;
    logic       err_q, err_d;
    logic [1:0] res_q, res_d;
    logic       vld_q, vld_d;
    logic       over_q, over_d;
    logic       win_q, win_d;
    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;
    logic [3:0] ev;
    logic [1:0] p1_in, p2_in;
    logic       unused_ok;

    function automatic logic beats(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a == 2'b01 && b == 2'b11) ||
               (a == 2'b11 && b == 2'b10) ||
               (a == 2'b10 && b == 2'b01);
    endfunction

    assign ev    = bus.ui_in[7:4] & ~hist_q;
    assign p1_in = bus.ui_in[1:0];
    assign p2_in = bus.ui_in[3:2];

    always_comb begin
        state_d = state_q;
        p1_mv_d = p1_mv_q;
        p2_mv_d = p2_mv_q;
        p1_lk_d = p1_lk_q;
        p2_lk_d = p2_lk_q;
        err_d   = err_q;
        res_d   = res_q;
        vld_d   = vld_q;
        over_d  = over_q;
        win_d   = win_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        if (ena) begin
            if (ev[3]) begin
                state_d = IDLE;
                p1_mv_d = 2'b00;
                p2_mv_d = 2'b00;
                p1_lk_d = 1'b0;
                p2_lk_d = 1'b0;
                err_d   = 1'b0;
                res_d   = 2'b00;
                vld_d   = 1'b0;
                over_d  = 1'b0;
                win_d   = 1'b0;
                s1_d    = 4'd0;
                s2_d    = 4'd0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ev[2]) begin
                            state_d = COLLECT;
                            p1_lk_d = 1'b0;
                            p2_lk_d = 1'b0;
                            err_d   = 1'b0;
                            vld_d   = 1'b0;
                        end
                    end
                    COLLECT: begin
                        if (ev[0] && !p1_lk_q) begin
                            if (p1_in == 2'b00) begin
                                err_d = 1'b1;
                            end else begin
                                p1_mv_d = p1_in;
                                p1_lk_d = 1'b1;
                            end
                        end
                        if (ev[1] && !p2_lk_q) begin
                            if (p2_in == 2'b00) begin
                                err_d = 1'b1;
                            end else begin
                                p2_mv_d = p2_in;
                                p2_lk_d = 1'b1;
                            end
                        end
                        if (p1_lk_d && p2_lk_d) state_d = JUDGE;
                    end
                    JUDGE: begin
                        vld_d   = 1'b1;
                        state_d = RESULT;
                        if (p1_mv_q == p2_mv_q) begin
                            res_d = 2'b11;
                        end else if (beats(p1_mv_q, p2_mv_q)) begin
                            res_d = 2'b01;
                            s1_d  = s1_q + 4'd1;
                            if (s1_d == WIN) begin
                                state_d = OVER;
                                over_d  = 1'b1;
                                win_d   = 1'b0;
                            end
                        end else begin
                            res_d = 2'b10;
                            s2_d  = s2_q + 4'd1;
                            if (s2_d == WIN) begin
                                state_d = OVER;
                                over_d  = 1'b1;
                                win_d   = 1'b1;
                            end
                        end
                    end
                    RESULT: begin
                        if (ev[2]) begin
                            state_d = COLLECT;
                            p1_mv_d = 2'b00;
                            p2_mv_d = 2'b00;
                            p1_lk_d = 1'b0;
                            p2_lk_d = 1'b0;
                            res_d   = 2'b00;
                            vld_d   = 1'b0;
                            err_d   = 1'b0;
                        end
                    end
                    OVER: begin
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Edge history tracks the pins even while disabled, so
    // edges seen with ena=0 are consumed and lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hist_q  <= 4'h0;
            p1_mv_q <= 2'b00;
            p2_mv_q <= 2'b00;
            p1_lk_q <= 1'b0;
            p2_lk_q <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= 2'b00;
            vld_q   <= 1'b0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            hist_q  <= bus.ui_in[7:4];
            p1_mv_q <= p1_mv_d;
            p2_mv_q <= p2_mv_d;
            p1_lk_q <= p1_lk_d;
            p2_lk_q <= p2_lk_d;
            err_q   <= err_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            over_q  <= over_d;
            win_q   <= win_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    assign bus.uo_out  = {win_q, over_q, p2_lk_q, p1_lk_q,
                          err_q, vld_q, res_q};
    assign bus.uio_out = {s2_q, s1_q};
    assign bus.uio_oe  = 8'hFF;
    assign unused_ok   = ^bus.uio_in;
endmodule

// File: tb/tb_stone_paper_scissors.sv
// Directed-vector bench for the stone/paper/scissors
// referee; expected values are hand computed.
module tb_stone_paper_scissors;
    logic clk;
    logic rst;
    logic ena;
    int   checks;
    int   errors;

    stone_paper_scissors_if bus ();

    stone_paper_scissors #(.WIN_SCORE(3)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string      tag,
        input logic [7:0] got,
        input logic [7:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Raise event bits for one cycle, then drop them so the
    // history returns to 0; the event edge plus one more edge
    // elapse before the caller samples.
    task automatic ev(input logic [3:0] e);
        bus.ui_in[7:4] = e;
        @(negedge clk);
        bus.ui_in[7:4] = 4'h0;
        @(negedge clk);
    endtask

    task automatic moves(input logic [1:0] p1, input logic [1:0] p2);
        bus.ui_in[3:0] = {p2, p1};
    endtask

    task automatic both(
        input string      tag,
        input logic [7:0] uo,
        input logic [7:0] uio
    );
        check({tag, "_uo"}, bus.uo_out, uo);
        check({tag, "_uio"}, bus.uio_out, uio);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ena = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        both("reset", 8'h00, 8'h00);
        check("uio_oe", bus.uio_oe, 8'hFF);

        // Round 1: stone beats scissors
        moves(2'b01, 2'b11);
        ev(4'b0100);
        both("start1", 8'h00, 8'h00);
        ev(4'b0001);
        both("p1lock", 8'h10, 8'h00);
        ev(4'b0010);
        both("r1", 8'h35, 8'h01);

        // Round 2: simultaneous paper locks draw
        ev(4'b0100);
        both("start2", 8'h00, 8'h01);
        moves(2'b10, 2'b10);
        ev(4'b0011);
        both("draw", 8'h37, 8'h01);

        // Round 3: P1 tries to lock with no move
        ev(4'b0100);
        moves(2'b00, 2'b10);
        ev(4'b0001);
        both("nomove", 8'h08, 8'h01);
        moves(2'b01, 2'b10);
        ev(4'b0001);
        both("relock", 8'h18, 8'h01);
        ev(4'b0001);
        both("repeat", 8'h18, 8'h01);
        ev(4'b0010);
        both("r3", 8'h3E, 8'h11);
        ev(4'b0100);
        both("errclr", 8'h00, 8'h11);

        // P2 wins twice more and takes the match
        ev(4'b0011);
        both("r4", 8'h36, 8'h21);
        ev(4'b0100);
        ev(4'b0011);
        both("over", 8'hF6, 8'h31);
        ev(4'b0100);
        both("overstart", 8'hF6, 8'h31);
        ev(4'b0011);
        both("overlock", 8'hF6, 8'h31);

        // Clear, then clear racing a lock in COLLECT
        ev(4'b1000);
        both("clear", 8'h00, 8'h00);
        ev(4'b0001);
        both("idlelock", 8'h00, 8'h00);
        ev(4'b0100);
        ev(4'b1001);
        both("clrlock", 8'h00, 8'h00);
        ev(4'b0011);
        both("afterclr", 8'h00, 8'h00);

        // Disabled: events are lost, state frozen
        ev(4'b0100);
        ena = 1'b0;
        ev(4'b0011);
        both("ena0", 8'h00, 8'h00);
        ena = 1'b1;
        @(negedge clk);
        both("ena1", 8'h00, 8'h00);
        ev(4'b0011);
        both("enajudge", 8'h36, 8'h10);
        ena = 1'b0;
        ev(4'b1000);
        both("ena0clr", 8'h36, 8'h10);
        ena = 1'b1;
        @(negedge clk);
        both("lostclr", 8'h36, 8'h10);

        // Reset mid-match
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        both("midrst", 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
